// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan capture block:
// FSM encoding, default settle length, and the active-low hex glyph table.
package sseg_pkg;

    localparam int STABLE_CYCLES_DEFAULT = 4;
    localparam int CNT_W                 = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Active-low {a,b,c,d,e,f,g} patterns; entry i is the glyph for hex digit i.
    localparam logic [15:0][6:0] GLYPHS = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

endpackage

// File: rtl/sseg_scan_capture_if.sv
// Bundle of display-bus inputs and decoded capture outputs for sseg_scan_capture.
interface sseg_scan_capture_if;
    import sseg_pkg::*;

    logic [3:0] an;
    logic [7:0] sseg;
    logic       clear;
    logic [3:0] hex0;
    logic [3:0] hex1;
    logic [3:0] hex2;
    logic [3:0] hex3;
    logic [3:0] dp_out;
    logic [3:0] digit_valid;
    logic       frame_valid;
    logic       cap_strobe;
    logic       err_pulse;
    logic       err_sticky;
    state_t     state_dbg;

    // No back-pressure: cap_strobe / err_pulse are single-cycle qualifiers that
    // mark the cycle in which hexN/dp_out changed (or a bad glyph was seen).
    modport master (
        output an, sseg, clear,
        input  hex0, hex1, hex2, hex3, dp_out, digit_valid, frame_valid,
        input  cap_strobe, err_pulse, err_sticky, state_dbg
    );

    modport slave (
        input  an, sseg, clear,
        output hex0, hex1, hex2, hex3, dp_out, digit_valid, frame_valid,
        output cap_strobe, err_pulse, err_sticky, state_dbg
    );

endinterface

// File: rtl/sseg_glyph_decode.sv
// Maps an active-low 7-segment pattern to its hex value; known=0 for any
// pattern that is not one of the sixteen hex glyphs.
module sseg_glyph_decode
    import sseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       known
);

    always_comb begin
        hex   = '0;
        known = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPHS[i]) begin
                hex   = 4'(i);
                known = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sseg_scan_capture.sv
// Snoops a multiplexed 4-digit seven-segment bus and captures each digit once
// its {an,sseg} pattern has been stable for STABLE_CYCLES registered samples.
module sseg_scan_capture
    import sseg_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    sseg_scan_capture_if.slave   bus
);

    localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);

    logic [3:0]       an_q, an_d;
    logic [7:0]       sseg_q, sseg_d;
    logic [11:0]      last_q, last_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0][3:0]  hex_q, hex_d;
    logic [3:0]       dp_q, dp_d;
    logic [3:0]       dv_q, dv_d;
    logic             strobe_q, strobe_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_sticky_q, err_sticky_d;

    logic [11:0]      sample;
    logic             same;
    logic             lit;
    logic [1:0]       idx;
    logic             fire;
    logic [3:0]       dec_hex;
    logic             dec_known;

    sseg_glyph_decode u_decode (
        .seg   (sseg_q[6:0]),
        .hex   (dec_hex),
        .known (dec_known)
    );

    assign sample = {an_q, sseg_q};
    assign same   = (sample == last_q);

    always_comb begin
        lit = 1'b1;
        idx = 2'd0;
        case (an_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: lit = 1'b0;
        endcase
    end

    always_comb begin
        an_d         = bus.an;
        sseg_d       = bus.sseg;
        last_d       = last_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        hex_d        = hex_q;
        dp_d         = dp_q;
        dv_d         = dv_q;
        strobe_d     = 1'b0;
        err_pulse_d  = 1'b0;
        err_sticky_d = err_sticky_q;
        fire         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (lit) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_W'(1);
                    last_d  = sample;
                end
            end
            ST_SETTLE: begin
                if (!lit) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    cnt_d  = CNT_W'(1);
                    last_d = sample;
                end else if (cnt_q + CNT_W'(1) == STABLE_N) begin
                    state_d = ST_HOLD;
                    cnt_d   = STABLE_N;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!same) begin
                    if (lit) begin
                        state_d = ST_SETTLE;
                        cnt_d   = CNT_W'(1);
                        last_d  = sample;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (fire) begin
            if (dec_known) begin
                hex_d[idx] = dec_hex;
                dp_d[idx]  = ~sseg_q[7];
                dv_d[idx]  = 1'b1;
                strobe_d   = 1'b1;
            end else begin
                err_pulse_d  = 1'b1;
                err_sticky_d = 1'b1;
            end
        end

        // clear wins over a same-cycle capture for the sticky flags only
        if (bus.clear) begin
            dv_d         = '0;
            err_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q         <= '1;
            sseg_q       <= '1;
            last_q       <= '1;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            hex_q        <= '0;
            dp_q         <= '0;
            dv_q         <= '0;
            strobe_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            last_q       <= last_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hex_q        <= hex_d;
            dp_q         <= dp_d;
            dv_q         <= dv_d;
            strobe_q     <= strobe_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bus.hex0        = hex_q[0];
    assign bus.hex1        = hex_q[1];
    assign bus.hex2        = hex_q[2];
    assign bus.hex3        = hex_q[3];
    assign bus.dp_out      = dp_q;
    assign bus.digit_valid = dv_q;
    assign bus.frame_valid = &dv_q;
    assign bus.cap_strobe  = strobe_q;
    assign bus.err_pulse   = err_pulse_q;
    assign bus.err_sticky  = err_sticky_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed bench for sseg_scan_capture: hand-computed vector table plus
// sequences for latency, glitch, bad glyph, scan rotation, clear and reset.
module tb_sseg_scan_capture;
    import sseg_pkg::*;

    logic clk = 1'b0;
    logic reset;

    sseg_scan_capture_if bus ();

    sseg_scan_capture #(.STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [7:0] sseg;
        int         kind;   // 0 capture, 1 bad glyph, 2 not lit
        int         digit;
        int         hex;
        logic       dp;
    } vec_t;

    vec_t vecs[16];
    int   checks = 0;
    int   errors = 0;
    int   strobe_cnt = 0;
    int   err_cnt = 0;
    int   first;
    int   exp_hex[4];
    logic [3:0] exp_dp;
    logic [3:0] exp_dv;
    logic [7:0] scan_pat[4];
    logic [3:0] a;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit hit, got %0d errors expected end of test", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        strobe_cnt += int'(bus.cap_strobe);
        err_cnt    += int'(bus.err_pulse);
    endtask

    task automatic drive(input logic [3:0] an, input logic [7:0] sseg);
        bus.an   = an;
        bus.sseg = sseg;
    endtask

    task automatic gap(input int n);
        drive(4'hF, 8'hFF);
        repeat (n) tick();
    endtask

    task automatic clear_pulse();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    function automatic int hex_of(input int d);
        case (d)
            0:       return int'(bus.hex0);
            1:       return int'(bus.hex1);
            2:       return int'(bus.hex2);
            default: return int'(bus.hex3);
        endcase
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_hex"},    int'({bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 0);
        check({tag, "_dp"},     int'(bus.dp_out), 0);
        check({tag, "_dv"},     int'(bus.digit_valid), 0);
        check({tag, "_fv"},     int'(bus.frame_valid), 0);
        check({tag, "_strobe"}, int'(bus.cap_strobe), 0);
        check({tag, "_errp"},   int'(bus.err_pulse), 0);
        check({tag, "_sticky"}, int'(bus.err_sticky), 0);
        check({tag, "_state"},  int'(bus.state_dbg), int'(ST_IDLE));
    endtask

    initial begin
        vecs[0]  = '{4'b1110, 8'b1_0000110, 0, 0, 4'h3, 1'b0};
        vecs[1]  = '{4'b1101, 8'b0_1001100, 0, 1, 4'h4, 1'b1};
        vecs[2]  = '{4'b1011, 8'b1_1100000, 0, 2, 4'hB, 1'b0};
        vecs[3]  = '{4'b0111, 8'b0_0110001, 0, 3, 4'hC, 1'b1};
        vecs[4]  = '{4'b1110, 8'b1_1000010, 0, 0, 4'hD, 1'b0};
        vecs[5]  = '{4'b1101, 8'b1_0000000, 0, 1, 4'h8, 1'b0};
        vecs[6]  = '{4'b1011, 8'b1_0100100, 0, 2, 4'h5, 1'b0};
        vecs[7]  = '{4'b0111, 8'b1_0001111, 0, 3, 4'h7, 1'b0};
        vecs[8]  = '{4'b1110, 8'b1_0110000, 0, 0, 4'hE, 1'b0};
        vecs[9]  = '{4'b1101, 8'b0_0000001, 0, 1, 4'h0, 1'b1};
        vecs[10] = '{4'b1011, 8'b1_0010010, 0, 2, 4'h2, 1'b0};
        vecs[11] = '{4'b0111, 8'b1_0100000, 0, 3, 4'h6, 1'b0};
        vecs[12] = '{4'b1110, 8'b0_0000100, 0, 0, 4'h9, 1'b1};
        vecs[13] = '{4'b1101, 8'b1_1111110, 1, 1, 4'h0, 1'b0};
        vecs[14] = '{4'b1100, 8'b1_0000110, 2, 0, 4'h0, 1'b0};
        vecs[15] = '{4'b0111, 8'b0_1001111, 0, 3, 4'h1, 1'b1};

        scan_pat[0] = 8'b1_1001111;
        scan_pat[1] = 8'b1_0010010;
        scan_pat[2] = 8'b0_0001000;
        scan_pat[3] = 8'b1_0111000;

        // Power-on reset
        reset     = 1'b1;
        bus.an    = 4'hF;
        bus.sseg  = 8'hFF;
        bus.clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        reset = 1'b0;

        // Single digit: latency and capture contents
        drive(4'b1110, 8'b1000_0110);
        strobe_cnt = 0;
        first = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (bus.cap_strobe && first == 0) first = t;
        end
        check("single_latency", first, 5);
        check("single_strobes", strobe_cnt, 1);
        check("single_hex0", int'(bus.hex0), 3);
        check("single_dp", int'(bus.dp_out), 0);
        check("single_dv", int'(bus.digit_valid), 4'b0001);

        // Short glitch inside a blank gap
        gap(3);
        strobe_cnt = 0;
        err_cnt = 0;
        drive(4'b1101, 8'b1100_1111);
        repeat (3) tick();
        gap(6);
        check("glitch_strobes", strobe_cnt, 0);
        check("glitch_errs", err_cnt, 0);
        check("glitch_dv", int'(bus.digit_valid), 4'b0001);

        // Blank pattern on a lit digit is an invalid glyph
        strobe_cnt = 0;
        err_cnt = 0;
        drive(4'b0111, 8'hFF);
        repeat (8) tick();
        check("bad_errs", err_cnt, 1);
        check("bad_strobes", strobe_cnt, 0);
        check("bad_sticky", int'(bus.err_sticky), 1);
        check("bad_dv", int'(bus.digit_valid), 4'b0001);
        check("bad_hex3", int'(bus.hex3), 0);
        clear_pulse();
        check("clr_sticky", int'(bus.err_sticky), 0);
        check("clr_dv", int'(bus.digit_valid), 0);

        // Vector table
        exp_hex = '{3, 0, 0, 0};
        exp_dp  = 4'b0000;
        exp_dv  = 4'b0000;
        for (int v = 0; v < 16; v++) begin
            gap(2);
            strobe_cnt = 0;
            err_cnt = 0;
            drive(vecs[v].an, vecs[v].sseg);
            repeat (7) tick();
            if (vecs[v].kind == 0) begin
                exp_hex[vecs[v].digit] = vecs[v].hex;
                exp_dp[vecs[v].digit]  = vecs[v].dp;
                exp_dv[vecs[v].digit]  = 1'b1;
            end
            check($sformatf("vec%0d_strobes", v), strobe_cnt, (vecs[v].kind == 0) ? 1 : 0);
            check($sformatf("vec%0d_errs", v), err_cnt, (vecs[v].kind == 1) ? 1 : 0);
            check($sformatf("vec%0d_hex", v), hex_of(vecs[v].digit), exp_hex[vecs[v].digit]);
            check($sformatf("vec%0d_dp", v), int'(bus.dp_out), int'(exp_dp));
            check($sformatf("vec%0d_dv", v), int'(bus.digit_valid), int'(exp_dv));
            if (vecs[v].kind == 1)
                check($sformatf("vec%0d_sticky", v), int'(bus.err_sticky), 1);
        end
        check("table_fv", int'(bus.frame_valid), 1);

        // Full scan rotation, two rounds
        gap(2);
        clear_pulse();
        check("scan_pre_fv", int'(bus.frame_valid), 0);
        strobe_cnt = 0;
        err_cnt = 0;
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++) begin
                a = 4'hF;
                a[d] = 1'b0;
                drive(a, scan_pat[d]);
                repeat (6) tick();
            end
        end
        check("scan_strobes", strobe_cnt, 8);
        check("scan_errs", err_cnt, 0);
        check("scan_fv", int'(bus.frame_valid), 1);
        check("scan_hex", int'({bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 16'hFA21);
        check("scan_dp", int'(bus.dp_out), 4'b0100);
        check("scan_dv", int'(bus.digit_valid), 4'b1111);

        // Clear in the same cycle as a capture of digit 1
        gap(2);
        clear_pulse();
        strobe_cnt = 0;
        drive(4'b1101, 8'b1_0100100);
        repeat (4) tick();
        check("cc_early_strobes", strobe_cnt, 0);
        bus.clear = 1'b1;
        tick();
        check("cc_strobe", int'(bus.cap_strobe), 1);
        check("cc_dv", int'(bus.digit_valid), 0);
        check("cc_hex1", int'(bus.hex1), 5);
        check("cc_fv", int'(bus.frame_valid), 0);
        bus.clear = 1'b0;
        tick();
        check("cc_hold_strobe", int'(bus.cap_strobe), 0);
        check("cc_hold_dv", int'(bus.digit_valid), 0);

        // Reset two clocks into a settling digit
        gap(2);
        drive(4'b1011, 8'b1_0000110);
        repeat (2) tick();
        reset = 1'b1;
        #1;
        check_reset_vals("mid");
        @(posedge clk);
        #1;
        reset = 1'b0;
        strobe_cnt = 0;
        first = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (bus.cap_strobe && first == 0) first = t;
        end
        check("rst_latency", first, 5);
        check("rst_strobes", strobe_cnt, 1);
        check("rst_hex2", int'(bus.hex2), 3);
        check("rst_dv", int'(bus.digit_valid), 4'b0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sseg_scan_capture.md
SSEG_SCAN_CAPTURE -- requirements
Module: sseg_scan_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive identical samples needed before a capture (legal range 2..255).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset  input  1  reset; asynchronous and active-high.
REQ-004 an  input  4  multiplexed anode enables; active-low, one-hot-low when a digit is lit.
REQ-005 sseg  input  8  segment bus; active-low; sseg[7]=dp, sseg[6:0]={a,b,c,d,e,f,g}.
REQ-006 clear  input  1  synchronous clear of digit_valid, frame_valid and err_sticky.
REQ-007 hex0..hex3  output  4 each  last decoded value of digit 0..3 (an[0]..an[3]).
REQ-008 dp_out  output  4  last captured dp per digit; 1 = dp lit.
REQ-009 digit_valid  output  4  sticky per-digit "captured since clear" flags.
REQ-010 frame_valid  output  1  high while digit_valid == 4'b1111.
REQ-011 cap_strobe  output  1  one-cycle pulse on each successful capture.
REQ-012 err_pulse  output  1  one-cycle pulse when a stable pattern is not a hex glyph.
REQ-013 err_sticky  output  1  set by err_pulse; cleared only by clear or reset.

Function
REQ-014 an and sseg SHALL be registered once on entry; all later logic uses the registered copy.
REQ-015 A sample SHALL be "lit" only when exactly one bit of registered an is 0.
REQ-016 FSM states: IDLE (no lit sample), SETTLE (counting identical lit samples), HOLD (captured, waiting for change).
REQ-017 IDLE->SETTLE on a lit sample; the stability counter loads 1.
REQ-018 In SETTLE, identical {an,sseg} increments the counter. A differing lit sample reloads 1. A non-lit sample goes to IDLE.
REQ-019 When the counter reaches STABLE_CYCLES, the FSM SHALL go to HOLD and perform exactly one capture or error on that edge.
REQ-020 HOLD SHALL perform no further capture. Any change of {an,sseg} goes to SETTLE (lit) or IDLE (not lit).
REQ-021 Decode table for sseg[6:0] (active-low {a..g}), 0..F:
- 0000001, 1001111, 0010010, 0000110
- 1001100, 0100100, 0100000, 0001111
- 0000000, 0000100, 0001000, 1100000
- 0110001, 1000010, 0110000, 0111000
REQ-022 Capture: hexN <= decoded value, dp_out[N] <= ~sseg[7], digit_valid[N] <= 1, cap_strobe pulse; N = index of the zero bit in an.
REQ-023 A pattern not in REQ-021 (including blank 1111111) SHALL pulse err_pulse, set err_sticky, and leave hexN, dp_out[N], digit_valid[N] unchanged.
REQ-024 Latency: pins stable from before edge k give a capture visible after edge k+STABLE_CYCLES (k+4 by default).
REQ-025 clear takes priority over a same-cycle capture for digit_valid and err_sticky. hexN/dp_out still update, and cap_strobe/err_pulse still pulse.
REQ-026 frame_valid SHALL be combinational from digit_valid.
REQ-027 Glitches shorter than STABLE_CYCLES SHALL never cause a capture.

Reset
REQ-028 Reset SHALL force FSM=IDLE, counter=0, input registers=all ones.
REQ-029 Reset SHALL force hex0..hex3=0, dp_out=0, digit_valid=0, frame_valid=0, cap_strobe=0, err_pulse=0, err_sticky=0.
REQ-030 Reset asserted mid-SETTLE SHALL abort the pending capture; no strobe follows deassertion.

Structure
REQ-031 Package sseg_pkg SHALL hold the REQ-021 glyph constants, the FSM state type/encoding, and the default STABLE_CYCLES.
REQ-032 Combinational sub-module sseg_glyph_decode SHALL map sseg[6:0] to {hex[3:0], known}. It is used once.
REQ-033 Target size: 120-400 RTL lines.

Verification
REQ-034 Single digit: an=1110, sseg=10000110 held 10 clocks. Expect one cap_strobe 4 clocks after registration, hex0=3, dp_out[0]=0, digit_valid=0001.
REQ-035 Full scan: 1 kHz-style rotation of digits 1,2,A,F with dp on digit 2. Expect frame_valid=1, hex3..0=F,A,2,1, dp_out=0100, one strobe per dwell.
REQ-036 Glitch: a 3-clock pulse of an=1101, sseg=11001111 inside an an=1111 gap. Expect no strobe and digit_valid unchanged.
REQ-037 Invalid glyph: an=0111, sseg=11111111 held. Expect one err_pulse, err_sticky=1, digit_valid[3]=0; then clear -> err_sticky=0.
REQ-038 Reset mid-SETTLE: assert reset 2 clocks into a stable digit, then release with inputs unchanged. Expect all outputs at reset values, and a fresh capture only after a full STABLE_CYCLES.
REQ-039 Clear vs capture: clear in the same cycle as a capture of digit 1. Expect digit_valid=0000, hex1 updated, cap_strobe=1.
